// File: rtl/e_mdu_pkg.sv
// Shared MDU definitions: operation encodings, datapath width and latency constants.
package e_mdu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned CNTW    = 4;
    localparam int unsigned MUL_LAT = 5;
    localparam int unsigned DIV_LAT = 10;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mduOp_t;

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with HI/LO registers and a fixed-latency busy counter.
// Optional macro MDU_DIV0_KEEP_EN: divide by zero leaves HI/LO unchanged.
module e_mdu
    import e_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            Start,
    input  logic [2:0]      MDUOp,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            Req,
    input  logic            ReadHi,
    output logic            Busy,
    output logic [XLEN-1:0] Out
);

    logic [CNTW-1:0] cnt, cntNext;
    mduOp_t          opReg, opNext;
    logic [XLEN-1:0] aReg, aNext, bReg, bNext;
    logic [XLEN-1:0] hi, hiNext, lo, loNext;

    logic              accept;
    logic              extA, extB;
    logic [2*XLEN-1:0] prod;
    logic              aNeg, bNeg, divZero;
    logic [XLEN-1:0]   aMag, bMag, qMag, rMag, quo, rem;

    assign Busy = (cnt != '0);
    assign Out  = ReadHi ? hi : lo;

    assign accept = Start && !Req && !Busy &&
                    (MDUOp >= MDU_MULT) && (MDUOp <= MDU_MTLO);

    // Low 64 bits of the product of extended operands equal the signed or unsigned product.
    assign extA = (opReg == MDU_MULT) && aReg[XLEN-1];
    assign extB = (opReg == MDU_MULT) && bReg[XLEN-1];
    assign prod = {{XLEN{extA}}, aReg} * {{XLEN{extB}}, bReg};

    // Sign-magnitude division: truncates toward zero, remainder follows the dividend.
    assign divZero = (bReg == '0);
    assign aNeg    = (opReg == MDU_DIV) && aReg[XLEN-1];
    assign bNeg    = (opReg == MDU_DIV) && bReg[XLEN-1];
    assign aMag    = aNeg ? (-aReg) : aReg;
    assign bMag    = bNeg ? (-bReg) : bReg;
    assign qMag    = divZero ? '0 : (aMag / bMag);
    assign rMag    = divZero ? '0 : (aMag % bMag);
    assign quo     = (aNeg ^ bNeg) ? (-qMag) : qMag;
    assign rem     = aNeg ? (-rMag) : rMag;

    always_comb begin
        cntNext = cnt;
        opNext  = opReg;
        aNext   = aReg;
        bNext   = bReg;
        hiNext  = hi;
        loNext  = lo;
        if (Busy) begin
            cntNext = cnt - CNTW'(1);
            if (cnt == CNTW'(1)) begin
                case (opReg)
                    MDU_MULT, MDU_MULTU: {hiNext, loNext} = prod;
                    MDU_DIV, MDU_DIVU: begin
`ifdef MDU_DIV0_KEEP_EN
                        if (!divZero) begin
                            loNext = quo;
                            hiNext = rem;
                        end
`else
                        if (divZero) begin
                            hiNext = aReg;
                            loNext = '1;
                        end else begin
                            loNext = quo;
                            hiNext = rem;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end else if (accept) begin
            opNext = mduOp_t'(MDUOp);
            aNext  = A;
            bNext  = B;
            case (mduOp_t'(MDUOp))
                MDU_MULT, MDU_MULTU: cntNext = CNTW'(MUL_LAT);
                MDU_DIV, MDU_DIVU:   cntNext = CNTW'(DIV_LAT);
                MDU_MTHI:            hiNext  = A;
                MDU_MTLO:            loNext  = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            opReg <= MDU_NONE;
            aReg  <= '0;
            bReg  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            cnt   <= cntNext;
            opReg <= opNext;
            aReg  <= aNext;
            bReg  <= bNext;
            hi    <= hiNext;
            lo    <= loNext;
        end
    end

endmodule
